// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/product widths, the final iteration index
// of the shift-and-add multiplier, and the multiply sequencer state type.
package alu_pkg;

  localparam int          OP_W      = 6;
  localparam int          PROD_W    = 12;
  localparam logic [2:0]  ITER_LAST = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/adder_6b.sv
// 6-bit ripple-carry adder.
// Ports:
//   i0, i1 : input  [5:0] addends
//   cin    : input        carry in
//   sum    : output [5:0] sum bits
//   cout   : output       carry out of bit 5
module adder_6b (
  input  logic [5:0] i0,
  input  logic [5:0] i1,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);

  logic [6:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 6; i++) begin
      sum[i]       = i0[i] ^ i1[i] ^ carry[i];
      carry[i + 1] = (i0[i] & i1[i]) | (carry[i] & (i0[i] ^ i1[i]));
    end
    cout = carry[6];
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing controller for a 6x6 unsigned shift-and-add multiplier.
// One adder_6b is time-shared over six iterations; start/done handshake.
// Ports:
//   clk     : input        rising-edge clock
//   reset   : input        asynchronous, active-high; clears all state
//   start   : input        multiply request, sampled only in IDLE
//   a, b    : input  [5:0] multiplicand / multiplier, captured on accept
//   busy    : output       high while iterating
//   done    : output       one-cycle pulse when product becomes valid
//   product : output [11:0] registered result, held until the next one lands
// Build option:
//   SEQ_MULT_ZERO_SKIP_EN - when defined, a zero operand skips the iterations
//   and finishes with product 0 one cycle after acceptance (busy stays low).
module seq_mult_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  mult_state_t     state;
  logic [OP_W-1:0] m;
  logic [OP_W-1:0] acc;
  logic [OP_W-1:0] q;
  logic [2:0]      cnt;

  logic [OP_W-1:0] addend;
  logic [OP_W-1:0] sum;
  logic            cout;
  logic [OP_W-1:0] acc_next;
  logic [OP_W-1:0] q_next;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend = q[0] ? m : '0;

  adder_6b u_adder (
    .i0   (acc),
    .i1   (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The 13-bit {cout, sum, q} value shifts right by one: the carry becomes
  // the accumulator MSB and the sum LSB drops into the top of q, so after six
  // iterations {acc, q} is the full 12-bit product.
  assign acc_next = {cout, sum[OP_W-1:1]};
  assign q_next   = {sum[0], q[OP_W-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef SEQ_MULT_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
              state   <= DONE;
              product <= '0;
              done    <= 1'b1;
            end else begin
              m     <= a;
              q     <= b;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
`else
            m     <= a;
            q     <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`endif
          end
        end

        RUN: begin
          acc <= acc_next;
          q   <= q_next;
          if (cnt == ITER_LAST) begin
            product <= {acc_next, q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        DONE: begin
          // start is ignored here; the next request is sampled back in IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  a     = '0;
  logic [5:0]  b     = '0;
  logic        busy;
  logic        done;
  logic [11:0] product;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  seq_mult_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline reference: an accepted request at edge e keeps busy high after
  // edges e..e+5, pulses done after edge e+6 with product a*b, and the next
  // request can be accepted at edge e+8. Zero-skip: done right after edge e,
  // next acceptance at e+2.
  int          e         = 0;
  int          free_from = 0;
  int          bs        = 1;
  int          be        = 0;
  int          dn        = -1;
  logic [11:0] pend      = '0;
  logic [11:0] m_prod    = '0;
  bit          m_busy    = 1'b0;
  bit          m_done    = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e = 0; free_from = 0; bs = 1; be = 0; dn = -1;
      m_prod = '0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      e++;
      if (start && e >= free_from) begin
        if (ZS && (a == 0 || b == 0)) begin
          pend = '0; dn = e; free_from = e + 2;
        end else begin
          pend = 12'(int'(a) * int'(b));
          bs = e; be = e + 5; dn = e + 6; free_from = e + 8;
        end
      end
      m_busy = (e >= bs) && (e <= be);
      m_done = (e == dn);
      if (e == dn) m_prod = pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_product", product, m_prod);
    end
  end

  task automatic run_mul(input logic [5:0] x, input logic [5:0] y, input bit noise,
                         output logic [11:0] p, output int lat, output int bcnt);
    bit got  = 1'b0;
    bit zero = (x == 0) || (y == 0);
    lat = 0; bcnt = 0; p = '0;
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #1;
      if (noise && n <= 5 && !(ZS && zero)) begin
        start = 1'($urandom); a = 6'($urandom); b = 6'($urandom);
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin got = 1'b1; lat = n; p = product; end
    end
    start = 1'b0;
    chk("run_mul_timeout", got, 1);
  endtask

  task automatic wait_done(output logic [11:0] p, output int n);
    bit got = 1'b0;
    n = 0; p = '0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; n = i; p = product; end
    end
    chk("wait_done_timeout", got, 1);
  endtask

  typedef struct { logic [5:0] x; logic [5:0] y; int exp; } vec_t;
  vec_t vecs [5];

  initial begin
    logic [11:0] p;
    int          lat;
    int          bcnt;
    int          ndone;

    vecs[0] = '{6'd63, 6'd63, 12'hF81};
    vecs[1] = '{6'd1,  6'd1,  12'h001};
    vecs[2] = '{6'd42, 6'd1,  12'h02A};
    vecs[3] = '{6'd1,  6'd42, 12'h02A};
    vecs[4] = '{6'd0,  6'd37, 0};

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Directed operands with hand-computed products.
    foreach (vecs[i]) begin
      bit zero = (vecs[i].x == 0) || (vecs[i].y == 0);
      run_mul(vecs[i].x, vecs[i].y, 1'b0, p, lat, bcnt);
      chk("dir_product", p, vecs[i].exp);
      chk("dir_latency", lat, (ZS && zero) ? 1 : 7);
      chk("dir_busy_cycles", bcnt, (ZS && zero) ? 0 : 6);
    end

    // start held high across RUN and DONE: second request waits for IDLE.
    @(posedge clk); #1;
    start = 1'b1; a = 6'd5; b = 6'd7;
    @(posedge clk); #1;
    a = 6'd9; b = 6'd9;
    wait_done(p, lat);
    chk("hold_first_product", p, 35);
    chk("hold_first_latency", lat, 6);
    wait_done(p, lat);
    chk("hold_second_product", p, 81);
    chk("hold_second_gap", lat, 8);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset in the third RUN cycle of 12*12 discards the operation.
    start = 1'b1; a = 6'd12; b = 6'd12;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    chk("midrun_reset_product", product, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("no_done_after_reset", ndone, 0);
    run_mul(6'd12, 6'd12, 1'b0, p, lat, bcnt);
    chk("fresh_12x12", p, 144);

    // All 4096 operand pairs in a scrambled order, with ignored start noise.
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] idx;
      idx = 12'((i * 2897 + 17) & 4095);
      run_mul(idx[11:6], idx[5:0], 1'b1, p, lat, bcnt);
      chk("sweep_product", p, int'(idx[11:6]) * int'(idx[5:0]));
      chk("sweep_latency", lat,
          (ZS && (idx[11:6] == 0 || idx[5:0] == 0)) ? 1 : 7);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
